// File: rtl/pal_pkg.sv
// Shared types and constants for the PAL fuse loader.
package pal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK,
    ST_COMMIT,
    ST_DONE
  } pal_state_e;

  // Checksum word is one row wide; this is also the default row width.
  localparam int PAL_CHK_W = 5;

  function automatic int pal_cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pal_row_shifter.sv
// Serial-to-parallel row assembler: MSB-first shift register plus bit counter.
// word already includes the bit presented this cycle, so a completed row is usable on its last edge.
module pal_row_shifter
  import pal_pkg::*;
#(
  parameter int W = PAL_CHK_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         bit_in,
  output logic [W-1:0] word,
  output logic         last
);

  localparam int CW = pal_cw(W);

  logic [CW-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == CW'(W - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = last ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  if (W > 1) begin : g_sr
    logic [W-2:0] sr_q, sr_d;

    assign word = {sr_q, bit_in};

    always_comb begin
      sr_d = sr_q;
      if (clr)     sr_d = '0;
      else if (en) sr_d = word[W-2:0];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) sr_q <= '0;
      else     sr_q <= sr_d;
    end
  end else begin : g_nosr
    assign word = bit_in;
  end

endmodule

// File: rtl/pal_fuse_loader.sv
// Serial fuse loader for a PAL AND-array: shifts rows in, optionally verifies an XOR checksum,
// then issues a one-cycle commit strobe. Checksum stage built only with PAL_LOADER_CHECKSUM_EN.
module pal_fuse_loader
  import pal_pkg::*;
#(
  parameter int NUM_INPUTS = PAL_CHK_W,
  parameter int SIZE       = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  output logic                  bit_ready,
  output logic [NUM_INPUTS-1:0] sel [SIZE],
  output logic                  wen,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int RW = pal_cw(SIZE);

  pal_state_e            state_q, state_d;
  logic [RW-1:0]         row_q, row_d;
  logic [NUM_INPUTS-1:0] sel_q [SIZE];
  logic [NUM_INPUTS-1:0] sel_d [SIZE];
  logic [NUM_INPUTS-1:0] word;
  logic                  accept, clr, word_last;

  assign bit_ready = (state_q == ST_SHIFT) || (state_q == ST_CHECK);
  assign busy      = bit_ready || (state_q == ST_COMMIT);
  assign wen       = (state_q == ST_COMMIT);
  assign done      = (state_q == ST_DONE);
  assign accept    = bit_ready && bit_valid;
  assign sel       = sel_q;

  pal_row_shifter #(.W(NUM_INPUTS)) u_shifter (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .en     (accept),
    .bit_in (bit_in),
    .word   (word),
    .last   (word_last)
  );

`ifdef PAL_LOADER_CHECKSUM_EN
  logic                  err_q, err_d;
  logic [NUM_INPUTS-1:0] xsum;

  assign error = err_q;

  always_comb begin
    xsum = '0;
    for (int i = 0; i < SIZE; i++) xsum = xsum ^ sel_q[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`else
  assign error = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    sel_d   = sel_q;
    clr     = 1'b0;
`ifdef PAL_LOADER_CHECKSUM_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_SHIFT;
          row_d   = '0;
          clr     = 1'b1;
`ifdef PAL_LOADER_CHECKSUM_EN
          err_d   = 1'b0;
`endif
        end
      end
      ST_SHIFT: begin
        if (accept && word_last) begin
          for (int i = 0; i < SIZE; i++)
            if (row_q == RW'(i)) sel_d[i] = word;
          if (row_q == RW'(SIZE - 1)) begin
            row_d = '0;
`ifdef PAL_LOADER_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_COMMIT;
`endif
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      ST_CHECK: begin
`ifdef PAL_LOADER_CHECKSUM_EN
        // Checksum word travels through the same shifter right after the last row.
        if (accept && word_last) begin
          if (word == xsum) begin
            state_d = ST_COMMIT;
          end else begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_COMMIT: state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      sel_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      sel_q   <= sel_d;
    end
  end

endmodule

// File: tb/tb_pal_fuse_loader.sv
// Self-checking bench for pal_fuse_loader (NUM_INPUTS=5, SIZE=5); table of loads plus a reset-abort sequence.
module tb_pal_fuse_loader;

  localparam int N = 5;
  localparam int S = 5;
`ifdef PAL_LOADER_CHECKSUM_EN
  localparam int NCHK = N;
  localparam int NV   = 5;
`else
  localparam int NCHK = 0;
  localparam int NV   = 3;
`endif

  logic         clk = 1'b0;
  logic         rst, start, bit_in, bit_valid;
  logic         bit_ready, wen, busy, done, error;
  logic [N-1:0] sel [S];

  pal_fuse_loader #(.NUM_INPUTS(N), .SIZE(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .sel       (sel),
    .wen       (wen),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [S-1:0][N-1:0] rows;
    logic [N-1:0]        chk;
    bit                  stall;
    int                  start_at;
    bit                  exp_wen;
    bit                  exp_err;
  } vec_t;

  typedef struct {
    logic [S-1:0][N-1:0] sel;
    bit                  wen;
    int                  lat;
    bit                  err;
  } exp_t;

  vec_t tbl [NV];
  exp_t sb [$];

  int n_vec = 0;
  int n_mis = 0;
  int cyc = 0;
  int wen_total = 0;
  int wen_cyc = 0;
  int wen_base, start_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (wen === 1'b1) begin
      wen_total <= wen_total + 1;
      wen_cyc   <= cyc;
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic get_bit(input vec_t t, input int k);
    if (k < S * N) return t.rows[k / N][N - 1 - (k % N)];
    return t.chk[N - 1 - (k - S * N)];
  endfunction

  task automatic drive_load(input vec_t t);
    int   stalls = 0;
    int   nb = S * N + NCHK;
    exp_t e;
    @(negedge clk);
    start     = 1'b1;
    start_cyc = cyc;
    wen_base  = wen_total;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_done_clr", done, 0);
    chk("start_err_clr", error, 0);
    for (int k = 0; k < nb; k++) begin
      if (t.stall && (k % 2 == 1)) begin
        bit_valid = 1'b0;
        @(negedge clk);
        stalls++;
      end
      bit_valid = 1'b1;
      bit_in    = get_bit(t, k);
      start     = (k == t.start_at);
      @(negedge clk);
    end
    bit_valid = 1'b0;
    start     = 1'b0;
    e.sel = t.rows;
    e.wen = t.exp_wen;
    e.lat = 1 + nb + stalls;
    e.err = t.exp_err;
    sb.push_back(e);
  endtask

  task automatic check_result();
    exp_t e;
    bit   seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("done_timeout", seen, 1);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    for (int r = 0; r < S; r++) chk($sformatf("sel[%0d]", r), sel[r], e.sel[r]);
    chk("wen_count", wen_total - wen_base, e.wen ? 1 : 0);
    if (e.wen) chk("wen_latency", wen_cyc - start_cyc, e.lat);
    chk("error", error, e.err);
    chk("busy_idle", busy, 0);
    chk("ready_idle", bit_ready, 0);
  endtask

  initial begin
    logic [S-1:0][N-1:0] ra, rb;
    int wb;
    ra = {5'b10001, 5'b00000, 5'b11111, 5'b01010, 5'b10101};  // row 0 in low slot
    rb = {5'b00001, 5'b10010, 5'b01100, 5'b00111, 5'b11000};
    tbl[0] = '{rows: ra, chk: 5'b10001, stall: 1'b0, start_at: -1, exp_wen: 1'b1, exp_err: 1'b0};
    tbl[1] = '{rows: ra, chk: 5'b10001, stall: 1'b1, start_at: -1, exp_wen: 1'b1, exp_err: 1'b0};
    tbl[2] = '{rows: rb, chk: 5'b00000, stall: 1'b0, start_at: 7,  exp_wen: 1'b1, exp_err: 1'b0};
`ifdef PAL_LOADER_CHECKSUM_EN
    tbl[3] = '{rows: ra, chk: 5'b00000, stall: 1'b0, start_at: -1, exp_wen: 1'b0, exp_err: 1'b1};
    tbl[4] = '{rows: rb, chk: 5'b00000, stall: 1'b1, start_at: 3,  exp_wen: 1'b1, exp_err: 1'b0};
`endif

    rst = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int r = 0; r < S; r++) chk($sformatf("rst_sel[%0d]", r), sel[r], 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", error, 0);
    chk("rst_wen", wen, 0);
    chk("rst_ready", bit_ready, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      drive_load(tbl[v]);
      check_result();
    end

    // Abort a load after 12 bits with an asynchronous reset.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    bit_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      bit_in = get_bit(tbl[0], k);
      @(negedge clk);
    end
    bit_valid = 1'b0;
    wb = wen_total;
    #2 rst = 1'b1;
    #1;
    for (int r = 0; r < S; r++) chk($sformatf("abort_sel[%0d]", r), sel[r], 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_wen", wen, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_wen", wen_total - wb, 0);

    drive_load(tbl[0]);
    check_result();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
